// File: rtl/program_counter.sv
// Program counter with load/increment, wrap pulse and optional halt detector (PC_HALT_DETECT_EN).
// Latency: one clk from sampled control to new out/wrap/halted; always accepts input, no backpressure.
module program_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out,
`ifdef PC_HALT_DETECT_EN
    output logic             halted,
`endif
    output logic             wrap
);

    logic [WIDTH-1:0] r_out;
    logic             r_wrap;
    logic             w_all_ones;

    assign w_all_ones = &r_out;
    assign out        = r_out;
    assign wrap       = r_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_out  <= in;
            r_wrap <= 1'b0;
        end else if (inc) begin
            r_out  <= r_out + WIDTH'(1);
            r_wrap <= w_all_ones;
        end else begin
            r_wrap <= 1'b0;
        end
    end

`ifdef PC_HALT_DETECT_EN
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_self_prev;
    logic   w_self_jump;

    // A self-jump is a taken load whose target equals the current count.
    assign w_self_jump = load && (in == r_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_self_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_self_prev <= w_self_jump;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN:  if (w_self_jump && r_self_prev) w_state_nxt = ST_HALT;
            ST_HALT: if (!w_self_jump) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign halted = (r_state == ST_HALT);
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed scenarios plus randomized traffic vs a behavioural model.
module tb_program_counter;

    localparam int W    = 16;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic         inc;
    logic [W-1:0] in_v;
    logic [W-1:0] out_v;
    logic         wrap_v;
`ifdef PC_HALT_DETECT_EN
    logic         halted_v;
`endif

    always #5 clk = ~clk;

    program_counter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_v),
        .load   (load),
        .inc    (inc),
        .out    (out_v),
`ifdef PC_HALT_DETECT_EN
        .halted (halted_v),
`endif
        .wrap   (wrap_v)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    test_fail_start;
    string test_name;

    // reference model state
    int m_out    = 0;
    int m_wrap   = 0;
    int m_streak = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s [%s]: got 0x%0h expected 0x%0h", tag, test_name, obs, exp);
        end
    endtask

    task automatic begin_test(input string name);
        test_name       = name;
        test_fail_start = n_fail;
    endtask

    task automatic end_test();
        if (n_fail == test_fail_start) $display("%s: PASSED", test_name);
        else $display("%s: FAILED (%0d)", test_name, n_fail - test_fail_start);
    endtask

    // Apply one cycle of control, advance the model, and compare every output.
    task automatic step(input logic r, input logic l, input logic i, input logic [W-1:0] d);
        reset = r;
        load  = l;
        inc   = i;
        in_v  = d;
        @(posedge clk);
        #1;
        if (r) begin
            m_out    = 0;
            m_wrap   = 0;
            m_streak = 0;
        end else begin
            if (l && int'(d) == m_out) m_streak = (m_streak >= 2) ? 2 : m_streak + 1;
            else m_streak = 0;
            if (l) begin
                m_out  = int'(d);
                m_wrap = 0;
            end else if (i) begin
                m_wrap = (m_out == MASK) ? 1 : 0;
                m_out  = (m_out + 1) % (MASK + 1);
            end else begin
                m_wrap = 0;
            end
        end
        check("out", 32'(out_v), 32'(m_out));
        check("wrap", 32'(wrap_v), 32'(m_wrap));
`ifdef PC_HALT_DETECT_EN
        check("halted", 32'(halted_v), (m_streak >= 2) ? 32'd1 : 32'd0);
`endif
    endtask

    initial begin
        logic         r, l, i;
        logic [W-1:0] d;
        int           sel;

        begin_test("reset_overrides_load");
        step(1'b1, 1'b1, 1'b0, 16'h1234);
        check("rst_out", 32'(out_v), 32'h0000);
        check("rst_wrap", 32'(wrap_v), 32'h0);
        end_test();

        begin_test("inc_then_load_priority");
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("inc1", 32'(out_v), 32'h1);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("inc2", 32'(out_v), 32'h2);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("inc3", 32'(out_v), 32'h3);
        step(1'b0, 1'b1, 1'b1, 16'h00FF);
        check("load_wins", 32'(out_v), 32'h00FF);
        end_test();

        begin_test("wrap_pulse");
        step(1'b0, 1'b1, 1'b0, 16'hFFFF);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("wrap_out0", 32'(out_v), 32'h0);
        check("wrap_hi", 32'(wrap_v), 32'h1);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("wrap_out1", 32'(out_v), 32'h1);
        check("wrap_lo", 32'(wrap_v), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'hFFFF);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        check("load0_out", 32'(out_v), 32'h0);
        check("load0_nowrap", 32'(wrap_v), 32'h0);
        end_test();

        begin_test("reset_mid_count");
        step(1'b0, 1'b1, 1'b0, 16'h0010);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("at_13", 32'(out_v), 32'h13);
        step(1'b1, 1'b0, 1'b1, 16'h0);
        check("mid_rst", 32'(out_v), 32'h0);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("post_rst", 32'(out_v), 32'h1);
        end_test();

`ifdef PC_HALT_DETECT_EN
        begin_test("halt_detect");
        step(1'b0, 1'b1, 1'b0, 16'h0040);
        step(1'b0, 1'b1, 1'b0, 16'h0040);
        check("halt_first", 32'(halted_v), 32'h0);
        step(1'b0, 1'b1, 1'b0, 16'h0040);
        check("halt_set", 32'(halted_v), 32'h1);
        step(1'b0, 1'b0, 1'b1, 16'h0);
        check("halt_out", 32'(out_v), 32'h41);
        check("halt_clr", 32'(halted_v), 32'h0);
        end_test();
`endif

        begin_test("random");
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(99) < 3);
            l   = ($urandom_range(99) < 30);
            i   = ($urandom_range(99) < 65);
            sel = $urandom_range(5);
            case (sel)
                0:       d = W'(m_out);
                1:       d = 16'hFFFF;
                2:       d = 16'hFFFE;
                3:       d = 16'h0000;
                default: d = W'($urandom);
            endcase
            step(r, l, i, d);
        end
        end_test();

        if (n_fail == 0) $display("All tests PASSED");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
